// File: rtl/nv_fifo_ctrl_64x116.sv
// Valid/ready FIFO controller for an external 64x116 two-port RAM (registered read address, combinational dout).
// Define NV_FIFO_CTRL_RD_FLOP_EN to register rd_pd through an extra output stage (one more cycle of latency).
module nv_fifo_ctrl_64x116 #(
  parameter int DW       = 116,
  parameter int AW       = 6,
  parameter int AFULL_TH = 60
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW:0]   fifo_cnt,
  output logic          fifo_afull,
  output logic [AW-1:0] ram_wa,
  output logic          ram_we,
  output logic [DW-1:0] ram_di,
  output logic [AW-1:0] ram_ra,
  output logic          ram_re,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd
);

  localparam logic [AW:0]   DEPTH_V  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   AFULL_V  = (AW+1)'(AFULL_TH);
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   unread_q, unread_d;
  logic          rvld_q, rvld_d;
  logic          afull_q, afull_d;
  logic          wr_rdy_s, push_s, pop_s, issue_s;
  logic          pwrbus_unused_s;

`ifdef NV_FIFO_CTRL_RD_FLOP_EN
  logic          s1_vld_q, s1_vld_d;
  logic [DW-1:0] out_pd_q, out_pd_d;
  logic          move_s;
`endif

  // Power control belongs to the RAM macro in the parent; nothing here consumes it.
  assign pwrbus_unused_s = ^pwrbus_ram_pd;

  // Handshake decode and next-state computation.
  always_comb begin
    wr_rdy_s = (cnt_q != DEPTH_V);
    push_s   = wr_pvld & wr_rdy_s;
    pop_s    = rvld_q & rd_prdy;
`ifdef NV_FIFO_CTRL_RD_FLOP_EN
    // The RAM-data stage may refill whenever it is empty or draining into the output flop.
    move_s   = s1_vld_q & (~rvld_q | rd_prdy);
    issue_s  = (unread_q != CNT_ZERO) & (~s1_vld_q | move_s);
`else
    issue_s  = (unread_q != CNT_ZERO) & (~rvld_q | rd_prdy);
`endif

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (issue_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Entries stay counted until popped, so the slot under the RAM read address is never reused early.
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    case ({push_s, issue_s})
      2'b10:   unread_d = unread_q + CNT_ONE;
      2'b01:   unread_d = unread_q - CNT_ONE;
      default: unread_d = unread_q;
    endcase

    afull_d = (cnt_d >= AFULL_V);

`ifdef NV_FIFO_CTRL_RD_FLOP_EN
    if (issue_s) begin
      s1_vld_d = 1'b1;
    end else if (move_s) begin
      s1_vld_d = 1'b0;
    end else begin
      s1_vld_d = s1_vld_q;
    end

    if (move_s) begin
      rvld_d   = 1'b1;
      out_pd_d = ram_dout;
    end else if (pop_s) begin
      rvld_d   = 1'b0;
      out_pd_d = out_pd_q;
    end else begin
      rvld_d   = rvld_q;
      out_pd_d = out_pd_q;
    end
`else
    if (issue_s) begin
      rvld_d = 1'b1;
    end else if (pop_s) begin
      rvld_d = 1'b0;
    end else begin
      rvld_d = rvld_q;
    end
`endif
  end

  // State registers with synchronous active-low reset; RAM contents are left untouched.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      cnt_q    <= CNT_ZERO;
      unread_q <= CNT_ZERO;
      rvld_q   <= 1'b0;
      afull_q  <= 1'b0;
`ifdef NV_FIFO_CTRL_RD_FLOP_EN
      s1_vld_q <= 1'b0;
      out_pd_q <= {DW{1'b0}};
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      unread_q <= unread_d;
      rvld_q   <= rvld_d;
      afull_q  <= afull_d;
`ifdef NV_FIFO_CTRL_RD_FLOP_EN
      s1_vld_q <= s1_vld_d;
      out_pd_q <= out_pd_d;
`endif
    end
  end

  assign wr_prdy    = wr_rdy_s;
  assign rd_pvld    = rvld_q;
  assign fifo_cnt   = cnt_q;
  assign fifo_afull = afull_q;
  assign ram_we     = push_s & nvdla_core_rstn;
  assign ram_wa     = wr_ptr_q;
  assign ram_di     = wr_pd;
  assign ram_re     = issue_s & nvdla_core_rstn;
  assign ram_ra     = rd_ptr_q;
`ifdef NV_FIFO_CTRL_RD_FLOP_EN
  assign rd_pd      = out_pd_q;
`else
  assign rd_pd      = ram_dout;
`endif

endmodule

// File: tb/tb_nv_fifo_ctrl_64x116.sv
// Randomized bench for nv_fifo_ctrl_64x116: a queue-based reference of the FIFO plus a RAM macro model.
module tb_nv_fifo_ctrl_64x116;

  localparam int DW = 116;
  localparam int AW = 6;
  localparam int AFULL_TH = 60;
  localparam int CW = DW + 1;
`ifdef NV_FIFO_CTRL_RD_FLOP_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk;
  logic          rstn;
  logic          wr_pvld, wr_prdy, rd_pvld, rd_prdy;
  logic [DW-1:0] wr_pd, rd_pd, ram_di, ram_dout;
  logic [AW:0]   fifo_cnt;
  logic          fifo_afull, ram_we, ram_re;
  logic [AW-1:0] ram_wa, ram_ra;
  logic [31:0]   pwrbus_ram_pd;

  nv_fifo_ctrl_64x116 dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .fifo_cnt       (fifo_cnt),
    .fifo_afull     (fifo_afull),
    .ram_wa         (ram_wa),
    .ram_we         (ram_we),
    .ram_di         (ram_di),
    .ram_ra         (ram_ra),
    .ram_re         (ram_re),
    .ram_dout       (ram_dout),
    .pwrbus_ram_pd  (pwrbus_ram_pd)
  );

  // RAM macro model: synchronous write, registered read address, combinational data out.
  logic [DW-1:0] mem [64];
  logic [AW-1:0] ra_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: entries in flight, in push order, with the cycle each was pushed.
  logic [DW-1:0] data_q[$];
  int            time_q[$];
  int            cyc = 0;
  int            n_push = 0;
  int            n_issue = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] rnd_pd();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  // One clock of normal operation: drive, check at negedge against the reference, then advance.
  task automatic step(input logic wv, input logic [DW-1:0] wd, input logic rr, output logic pushed);
    logic exp_rvld, exp_push, exp_pop;
    int   sz;
    wr_pvld = wv;
    wr_pd   = wd;
    rd_prdy = rr;
    @(negedge clk);
    sz       = data_q.size();
    exp_rvld = (sz != 0) && (time_q[0] + LAT <= cyc);
    exp_push = wv && (sz != 64);
    exp_pop  = exp_rvld && rr;
    chk("wr_prdy",    CW'(wr_prdy),    CW'(sz != 64));
    chk("rd_pvld",    CW'(rd_pvld),    CW'(exp_rvld));
    chk("fifo_cnt",   CW'(fifo_cnt),   CW'(sz));
    chk("fifo_afull", CW'(fifo_afull), CW'(sz >= AFULL_TH));
    chk("ram_we",     CW'(ram_we),     CW'(exp_push));
    if (exp_push) begin
      chk("ram_wa", CW'(ram_wa), CW'(n_push % 64));
      chk("ram_di", CW'(ram_di), CW'(wd));
    end
    if (exp_rvld) chk("rd_pd", CW'(rd_pd), CW'(data_q[0]));
    if (ram_re) begin
      chk("ram_ra", CW'(ram_ra), CW'(n_issue % 64));
      chk("re_has_entry", CW'(n_issue < n_push), CW'(1));
      n_issue++;
    end
    if (exp_pop) begin
      void'(data_q.pop_front());
      void'(time_q.pop_front());
    end
    if (exp_push) begin
      data_q.push_back(wd);
      time_q.push_back(cyc);
      n_push++;
    end
    pushed = exp_push;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      rstn    = 1'b0;
      wr_pvld = 1'b1;
      wr_pd   = rnd_pd();
      rd_prdy = 1'b1;
      @(negedge clk);
      chk("rst_ram_we", CW'(ram_we), CW'(0));
      chk("rst_ram_re", CW'(ram_re), CW'(0));
      @(posedge clk);
      #1;
      cyc++;
    end
    rstn = 1'b1;
    data_q.delete();
    time_q.delete();
    n_push  = 0;
    n_issue = 0;
  endtask

  task automatic drain(input string tag);
    logic p;
    int   c;
    c = 0;
    while (data_q.size() != 0 && c < 300) begin
      step(1'b0, rnd_pd(), 1'b1, p);
      c++;
    end
    chk(tag, CW'(data_q.size()), CW'(0));
  endtask

  initial begin
    logic p;
    int   k, c;
    rstn = 1'b0;
    wr_pvld = 1'b0;
    rd_prdy = 1'b0;
    wr_pd = '0;
    pwrbus_ram_pd = 32'h0;
    #1;
    do_reset(2);

    // Single push with the reader always ready.
    step(1'b1, DW'(116'h1234), 1'b1, p);
    for (int i = 0; i < 5; i++) step(1'b0, rnd_pd(), 1'b1, p);

    // Fill to full with reader stalled, then offer more.
    for (int i = 0; i < 64; i++) step(1'b1, rnd_pd(), 1'b0, p);
    for (int i = 0; i < 3; i++) step(1'b1, rnd_pd(), 1'b0, p);

    // Full with both sides active.
    for (int i = 0; i < 12; i++) step(1'b1, rnd_pd(), 1'b1, p);
    drain("drain_full");

    // Random stream of incrementing words across several pointer wraps.
    k = 0;
    c = 0;
    while (!(k == 200 && data_q.size() == 0) && c < 5000) begin
      step((k < 200) && ($urandom_range(0, 3) != 0), DW'(32'h1000 + k),
           ($urandom_range(0, 3) != 0), p);
      if (p) k++;
      c++;
    end
    chk("stream_done", CW'(k == 200 && data_q.size() == 0), CW'(1));

    // Full-rate stream with both sides always active.
    for (int i = 0; i < 40; i++) step(1'b1, rnd_pd(), 1'b1, p);
    drain("drain_rate");

    // Mid-operation reset with pending output.
    for (int i = 0; i < 10; i++) step(1'b1, rnd_pd(), 1'b0, p);
    for (int i = 0; i < 3; i++) step(1'b0, rnd_pd(), 1'b0, p);
    do_reset(1);
    step(1'b1, DW'(116'hABC), 1'b1, p);
    for (int i = 0; i < 5; i++) step(1'b0, rnd_pd(), 1'b1, p);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
